// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, fetches over req/ack, applies execute redirects,
// buffers one instruction toward decode and supports halt/resume.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  input  logic             redir_valid,
  input  logic [1:0]       redir_type,
  input  logic [31:0]      redir_pc,
  input  logic [31:0]      redir_ext18,
  input  logic [25:0]      redir_target,
  input  logic [31:0]      redir_rs,
  input  logic             halt,
  input  logic             go,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {START, FETCH, HOLD, HALT} state_t;
  state_t           r_state, w_nxt;
  logic [31:0]      r_pc, r_addr, r_instr, r_ifpc, w_tgt, w_pc_n;
  logic             r_kill, r_halt_pend, w_redir, w_ack, w_load, w_take, w_hstop;
  logic [CNT_W-1:0] r_cnt;
  always_comb begin
    w_redir = redir_valid & (redir_type != 2'b11);
    w_tgt   = (redir_type == 2'b00) ? redir_pc + 32'd4 + redir_ext18 :
              (redir_type == 2'b01) ? redir_rs : {redir_pc[31:28], redir_target, 2'b00};
    w_ack   = imem_ack & (r_state == FETCH);
    w_load  = w_ack & ~r_kill & ~w_redir;
    w_take  = (r_state == HOLD) & if_ready & ~w_redir;
    w_hstop = r_halt_pend | halt;
    w_pc_n  = w_redir ? w_tgt : w_load ? r_pc + 32'd4 : r_pc;
    w_nxt   = r_state;
    case (r_state)
      START: w_nxt = FETCH;
      FETCH: w_nxt = w_load ? HOLD : FETCH;
      HOLD:  w_nxt = (w_redir | if_ready) ? (w_hstop ? HALT : FETCH) : HOLD;
      HALT:  w_nxt = go ? FETCH : HALT;
      default: w_nxt = START;
    endcase
  end
  // The request address only moves once the outstanding access has been acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= START;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_kill      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_instr     <= '0;
      r_ifpc      <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_nxt;
      r_pc        <= w_pc_n;
      r_addr      <= (r_state != FETCH || w_ack) ? w_pc_n : r_addr;
      r_kill      <= (r_state == FETCH) & ~imem_ack & (r_kill | w_redir);
      r_halt_pend <= (w_nxt == HALT) ? 1'b0 : r_halt_pend | (halt & (r_state != HALT));
      if (w_load) begin
        r_instr <= imem_rdata;
        r_ifpc  <= r_addr;
      end
      if (w_take) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_addr;
  assign if_valid    = (r_state == HOLD) & ~w_redir;
  assign if_instr    = r_instr;
  assign if_pc       = r_ifpc;
  assign halted      = (r_state == HALT);
  assign fetch_count = r_cnt;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed checks of fetch sequencing, redirects, halt and reset.
module tb_pc_fetch_sequencer;
  logic        clk = 0, rst_n = 0;
  logic        imem_req, imem_ack = 0, if_valid, if_ready = 0;
  logic [31:0] imem_addr, imem_rdata = 0, if_instr, if_pc;
  logic        redir_valid = 0, halt = 0, go = 0, halted;
  logic [1:0]  redir_type = 0;
  logic [31:0] redir_pc = 0, redir_ext18 = 0, redir_rs = 0, fetch_count;
  logic [25:0] redir_target = 0;
  int checks = 0, errors = 0;

  pc_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .redir_valid(redir_valid), .redir_type(redir_type), .redir_pc(redir_pc),
    .redir_ext18(redir_ext18), .redir_target(redir_target), .redir_rs(redir_rs),
    .halt(halt), .go(go), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", if_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_ifpc", if_pc, 0);
    #1 rst_n = 1;
    chk("start_req", imem_req, 0);
    cyc();
    chk("f0_req", imem_req, 1);
    chk("f0_addr", imem_addr, 32'h0);
    imem_ack = 1; imem_rdata = 32'h1111_0000; if_ready = 1;
    cyc();
    chk("h0_req", imem_req, 0);
    chk("h0_valid", if_valid, 1);
    chk("h0_pc", if_pc, 32'h0);
    chk("h0_instr", if_instr, 32'h1111_0000);
    imem_ack = 0;
    cyc();
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_cnt", fetch_count, 1);
    imem_ack = 1; imem_rdata = 32'h1111_0004;
    cyc();
    chk("h1_pc", if_pc, 32'h4);
    imem_ack = 0;
    cyc();
    chk("f2_addr", imem_addr, 32'h8);
    imem_ack = 1; imem_rdata = 32'h1111_0008;
    cyc();
    chk("h2_pc", if_pc, 32'h8);
    imem_ack = 0;
    cyc();
    chk("seq_cnt3", fetch_count, 3);
    chk("f3_addr", imem_addr, 32'hC);
    // jump to 0x40 while the fetch of 0xC is outstanding
    redir_valid = 1; redir_type = 2'b10; redir_pc = 0; redir_target = 26'h10;
    cyc();
    chk("kill_addr_hold", imem_addr, 32'hC);
    chk("kill_req", imem_req, 1);
    redir_valid = 0; imem_ack = 1; imem_rdata = 32'hDEAD_000C; if_ready = 0;
    cyc();
    chk("kill_dropped_pc", if_pc, 32'h8);
    chk("kill_next_addr", imem_addr, 32'h40);
    imem_rdata = 32'h2222_0040;
    cyc();
    chk("h40_pc", if_pc, 32'h40);
    chk("h40_valid", if_valid, 1);
    imem_ack = 0;
    cyc();
    chk("stall_valid", if_valid, 1);
    chk("stall_pc", if_pc, 32'h40);
    chk("stall_cnt", fetch_count, 3);
    if_ready = 1; redir_valid = 1; redir_type = 2'b00; redir_pc = 32'h3C; redir_ext18 = 32'hFFFF_FFF0;
    #1;
    chk("br_mask_valid", if_valid, 0);
    cyc();
    chk("br_addr", imem_addr, 32'h30);
    chk("br_cnt", fetch_count, 3);
    chk("br_req", imem_req, 1);
    redir_type = 2'b01; redir_rs = 32'h1000;
    cyc();
    chk("jr_hold1", imem_addr, 32'h30);
    redir_valid = 0;
    cyc();
    chk("jr_hold2", imem_addr, 32'h30);
    imem_ack = 1; imem_rdata = 32'hBAD0_0030;
    cyc();
    chk("jr_addr", imem_addr, 32'h1000);
    chk("jr_drop", if_pc, 32'h40);
    imem_rdata = 32'h3333_1000;
    cyc();
    chk("jr_hold_pc", if_pc, 32'h1000);
    chk("jr_instr", if_instr, 32'h3333_1000);
    imem_ack = 0;
    cyc();
    chk("jr_cnt", fetch_count, 4);
    chk("jr_next", imem_addr, 32'h1004);
    // jump coincident with the ack: data dropped, jump wins
    imem_ack = 1; redir_valid = 1; redir_type = 2'b10; redir_pc = 32'hA000_0010; redir_target = 26'h0000123;
    cyc();
    chk("jmp_addr", imem_addr, 32'hA000_048C);
    chk("jmp_drop", if_pc, 32'h1000);
    redir_valid = 0; imem_ack = 0;
    // reserved type is ignored
    redir_valid = 1; redir_type = 2'b11; redir_rs = 32'h5555;
    cyc();
    chk("rsvd_addr", imem_addr, 32'hA000_048C);
    redir_valid = 0; halt = 1;
    cyc();
    chk("halt_req", imem_req, 1);
    halt = 0; imem_ack = 1; imem_rdata = 32'h4444_048C;
    cyc();
    chk("halt_deliver_pc", if_pc, 32'hA000_048C);
    chk("halt_deliver_valid", if_valid, 1);
    imem_ack = 0;
    cyc();
    chk("halted", halted, 1);
    chk("halted_req", imem_req, 0);
    chk("halted_valid", if_valid, 0);
    chk("halted_cnt", fetch_count, 5);
    cyc();
    chk("halted_stay", halted, 1);
    go = 1; halt = 1;
    cyc();
    go = 0; halt = 0;
    chk("go_halted", halted, 0);
    chk("go_addr", imem_addr, 32'hA000_0490);
    cyc();
    rst_n = 0;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req", imem_req, 0);
    chk("arst_cnt", fetch_count, 0);
    chk("arst_halted", halted, 0);
    rst_n = 1; imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
    cyc();
    chk("late_ack_pc", if_pc, 32'h0);
    chk("late_ack_instr", if_instr, 32'h0);
    chk("late_ack_addr", imem_addr, 32'h0);
    chk("late_ack_req", imem_req, 1);
    imem_rdata = 32'h5555_0000;
    cyc();
    chk("post_rst_instr", if_instr, 32'h5555_0000);
    chk("post_rst_valid", if_valid, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
